// File: rtl/oam_write_responder.sv
// OAM write responder: buffers CPU sprite-attribute writes in a FIFO and commits
// them by read-modify-write into the sprite table only while vblank is high.
module oam_write_responder #(
  parameter int NUM_SPRITES = 64,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        oam_wr_en,
  input  logic [5:0]  oam_snum,
  input  logic [3:0]  oam_mask,
  input  logic [31:0] oam_wr_data,
  output logic        oam_full,
  output logic        oam_pending,
  output logic        oam_overflow,
  input  logic        oam_ovf_clr,
  input  logic        vblank,
  input  logic        ppu_rd_en,
  input  logic [5:0]  ppu_rd_addr,
  output logic [31:0] ppu_rd_data,
  output logic        ppu_rd_valid,
  output logic [1:0]  commit_state
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2} state_t;

  state_t        state;
  logic [5:0]    fifo_snum [FIFO_DEPTH];
  logic [3:0]    fifo_mask [FIFO_DEPTH];
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   oam [NUM_SPRITES];
  logic [5:0]    m_snum;
  logic [3:0]    m_mask;
  logic [31:0]   m_data, m_old, merged;
  logic          push, pop;

  assign oam_full     = (count == DEPTH_C);
  assign oam_pending  = (count != '0);
  assign push         = oam_wr_en && !oam_full;
  assign pop          = (state == WRITE);
  assign commit_state = state;

  // Per-field select between the requested data and the latched old entry.
  assign merged = {m_mask[3] ? m_data[31:28] : m_old[31:28],
                   m_mask[2] ? m_data[27:20] : m_old[27:20],
                   m_mask[1] ? m_data[19:10] : m_old[19:10],
                   m_mask[0] ? m_data[9:0]   : m_old[9:0]};

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_snum[wr_ptr] <= oam_snum;
      fifo_mask[wr_ptr] <= oam_mask;
      fifo_data[wr_ptr] <= oam_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      oam_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new overflow event takes priority over a clear in the same cycle.
      if (oam_wr_en && oam_full) oam_overflow <= 1'b1;
      else if (oam_ovf_clr)      oam_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      m_snum <= '0;
      m_mask <= '0;
      m_data <= '0;
      m_old  <= '0;
      for (int i = 0; i < NUM_SPRITES; i++) oam[i] <= '0;
    end else begin
      case (state)
        IDLE: if (oam_pending && vblank) state <= READ;
        READ: begin
          m_snum <= fifo_snum[rd_ptr];
          m_mask <= fifo_mask[rd_ptr];
          m_data <= fifo_data[rd_ptr];
          m_old  <= oam[fifo_snum[rd_ptr]];
          state  <= vblank ? WRITE : IDLE;
        end
        WRITE: begin
          oam[m_snum] <= merged;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // PPU read port samples the table before any same-edge commit lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ppu_rd_data  <= '0;
      ppu_rd_valid <= 1'b0;
    end else begin
      ppu_rd_valid <= ppu_rd_en;
      if (ppu_rd_en) ppu_rd_data <= oam[ppu_rd_addr];
    end
  end
endmodule

// File: tb/tb_oam_write_responder.sv
// Directed bench for oam_write_responder: table of merge writes plus hand-written
// sequences for overflow, vblank aborts, drain timing and mid-commit reset.
module tb_oam_write_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        oam_wr_en, oam_ovf_clr, vblank, ppu_rd_en;
  logic [5:0]  oam_snum, ppu_rd_addr;
  logic [3:0]  oam_mask;
  logic [31:0] oam_wr_data, ppu_rd_data;
  logic        oam_full, oam_pending, oam_overflow, ppu_rd_valid;
  logic [1:0]  commit_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  snum;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] shadow [64];

  oam_write_responder dut (
    .clk(clk), .rst(rst), .oam_wr_en(oam_wr_en), .oam_snum(oam_snum),
    .oam_mask(oam_mask), .oam_wr_data(oam_wr_data), .oam_full(oam_full),
    .oam_pending(oam_pending), .oam_overflow(oam_overflow),
    .oam_ovf_clr(oam_ovf_clr), .vblank(vblank), .ppu_rd_en(ppu_rd_en),
    .ppu_rd_addr(ppu_rd_addr), .ppu_rd_data(ppu_rd_data),
    .ppu_rd_valid(ppu_rd_valid), .commit_state(commit_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_check(input string name, input logic [5:0] addr, input logic [31:0] exp);
    ppu_rd_en   = 1'b1;
    ppu_rd_addr = addr;
    tick();
    ppu_rd_en = 1'b0;
    check({name, "_valid"}, 32'(ppu_rd_valid), 32'd1);
    check(name, ppu_rd_data, exp);
  endtask

  task automatic push(input logic [5:0] s, input logic [3:0] m, input logic [31:0] d);
    oam_wr_en   = 1'b1;
    oam_snum    = s;
    oam_mask    = m;
    oam_wr_data = d;
    tick();
    oam_wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; oam_wr_en = 1'b0; oam_ovf_clr = 1'b0; vblank = 1'b0;
    ppu_rd_en = 1'b0; oam_snum = '0; ppu_rd_addr = '0; oam_mask = '0; oam_wr_data = '0;
    for (int i = 0; i < 64; i++) shadow[i] = '0;

    vecs[0] = '{6'd3,  4'hF, 32'hA5C3_2010, 32'hA5C3_2010};
    vecs[1] = '{6'd3,  4'h1, 32'h0000_03FF, 32'hA5C3_23FF};
    vecs[2] = '{6'd3,  4'h2, 32'h000F_FC00, 32'hA5CF_FFFF};
    vecs[3] = '{6'd3,  4'h4, 32'h0AB0_0000, 32'hAABF_FFFF};
    vecs[4] = '{6'd3,  4'h8, 32'h5000_0000, 32'h5ABF_FFFF};
    vecs[5] = '{6'd3,  4'h0, 32'hFFFF_FFFF, 32'h5ABF_FFFF};
    vecs[6] = '{6'd63, 4'hF, 32'h1234_5678, 32'h1234_5678};
    vecs[7] = '{6'd0,  4'h5, 32'hFFFF_FFFF, 32'h0FF0_03FF};
    vecs[8] = '{6'd63, 4'hA, 32'h0000_0000, 32'h0230_0278};

    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("rst_full", 32'(oam_full), 32'd0);
    check("rst_pending", 32'(oam_pending), 32'd0);
    check("rst_overflow", 32'(oam_overflow), 32'd0);
    check("rst_state", 32'(commit_state), 32'd0);
    check("rst_rd_valid", 32'(ppu_rd_valid), 32'd0);
    read_check("rst_read5", 6'd5, 32'h0);
    tick();
    check("rd_valid_drop", 32'(ppu_rd_valid), 32'd0);

    // Commit latency: push at E0, READ at E1, WRITE at E2, OAM updated at E3.
    vblank = 1'b1;
    for (int v = 0; v < 9; v++) begin
      push(vecs[v].snum, vecs[v].mask, vecs[v].data);
      check("vec_pending_e0", 32'(oam_pending), 32'd1);
      tick();
      check("vec_state_e1", 32'(commit_state), 32'd1);
      tick();
      check("vec_state_e2", 32'(commit_state), 32'd2);
      ppu_rd_en   = 1'b1;
      ppu_rd_addr = vecs[v].snum;
      tick();
      check("vec_precommit_read", ppu_rd_data, shadow[vecs[v].snum]);
      check("vec_pending_e3", 32'(oam_pending), 32'd0);
      tick();
      ppu_rd_en = 1'b0;
      check("vec_commit_read", ppu_rd_data, vecs[v].exp);
      shadow[vecs[v].snum] = vecs[v].exp;
    end

    // Fill while scanning, overflow, then drain in 24 cycles.
    vblank = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push(6'(10 + i), 4'hF, 32'h1000_0000 + 32'(i));
      if (i == 6) check("not_full_at_7", 32'(oam_full), 32'd0);
    end
    check("full_at_8", 32'(oam_full), 32'd1);
    check("no_ovf_yet", 32'(oam_overflow), 32'd0);
    push(6'd18, 4'hF, 32'hBAD0_0000);
    check("ovf_set", 32'(oam_overflow), 32'd1);
    read_check("ovf_oam_untouched", 6'd10, 32'h0);
    oam_ovf_clr = 1'b1;
    tick();
    oam_ovf_clr = 1'b0;
    check("ovf_clr", 32'(oam_overflow), 32'd0);
    oam_ovf_clr = 1'b1;
    push(6'd18, 4'hF, 32'hBAD0_0000);
    oam_ovf_clr = 1'b0;
    check("ovf_set_wins", 32'(oam_overflow), 32'd1);
    vblank = 1'b1;
    repeat (23) tick();
    check("drain_pending_23", 32'(oam_pending), 32'd1);
    tick();
    check("drain_pending_24", 32'(oam_pending), 32'd0);
    for (int i = 0; i < 8; i++)
      read_check("drain_entry", 6'(10 + i), 32'h1000_0000 + 32'(i));
    read_check("dropped_entry", 6'd18, 32'h0);

    // Same-sprite writes merge in FIFO order.
    vblank = 1'b0;
    push(6'd20, 4'hF, 32'h1111_1111);
    push(6'd20, 4'h4, 32'h0EE0_0000);
    push(6'd20, 4'h1, 32'h0000_00AA);
    vblank = 1'b1;
    repeat (9) tick();
    check("order_pending", 32'(oam_pending), 32'd0);
    read_check("order_merge", 6'd20, 32'h1EE1_10AA);

    // vblank falls in READ: abort, no pop; falls in WRITE: commit completes.
    vblank = 1'b0;
    push(6'd30, 4'hF, 32'hCAFE_BABE);
    vblank = 1'b1;
    tick();
    check("abort_in_read", 32'(commit_state), 32'd1);
    vblank = 1'b0;
    tick();
    check("abort_state", 32'(commit_state), 32'd0);
    check("abort_pending", 32'(oam_pending), 32'd1);
    read_check("abort_oam", 6'd30, 32'h0);
    vblank = 1'b1;
    tick();
    tick();
    check("in_write", 32'(commit_state), 32'd2);
    vblank = 1'b0;
    tick();
    check("write_done_pending", 32'(oam_pending), 32'd0);
    read_check("write_done_oam", 6'd30, 32'hCAFE_BABE);

    // Reset asserted mid-WRITE with further entries queued.
    for (int i = 0; i < 5; i++) push(6'(40 + i), 4'hF, 32'hDEAD_0000 + 32'(i));
    vblank = 1'b1;
    tick();
    tick();
    check("pre_rst_state", 32'(commit_state), 32'd2);
    rst = 1'b0;
    #1;
    check("async_rst_pending", 32'(oam_pending), 32'd0);
    check("async_rst_full", 32'(oam_full), 32'd0);
    check("async_rst_state", 32'(commit_state), 32'd0);
    check("async_rst_ovf", 32'(oam_overflow), 32'd0);
    tick();
    rst = 1'b1;
    repeat (10) tick();
    check("post_rst_pending", 32'(oam_pending), 32'd0);
    read_check("post_rst_40", 6'd40, 32'h0);
    read_check("post_rst_3", 6'd3, 32'h0);
    read_check("post_rst_63", 6'd63, 32'h0);
    read_check("post_rst_30", 6'd30, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
